// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and constants for the wait-stated data-memory responder.
//   dmem_state_t : responder FSM state (IDLE, WAIT, RESP)
//   DMEM_CNT_W   : width of the wait-cycle counter
//   DMEM_WORD_W  : data word width
package dmem_pkg;

   localparam int DMEM_CNT_W  = 4;
   localparam int DMEM_WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array
// Word-organised storage behind the responder: 2^ADDR_W x 32 bits, one
// byte-enabled write port and one registered read port sharing an address.
// Contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   write strobe (bytes selected by be)
//   re     in   read strobe; rdata updates on the following edge
//   addr   in   word address [ADDR_W-1:0]
//   wdata  in   write data
//   be     in   byte enables, be[i] writes wdata[8i+7:8i]
//   rdata  out  registered read data (holds its value when re=0)
module dmem_array
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic                   re,
   input  logic [ADDR_W-1:0]      addr,
   input  logic [DMEM_WORD_W-1:0] wdata,
   input  logic [3:0]             be,
   output logic [DMEM_WORD_W-1:0] rdata
);

   logic [DMEM_WORD_W-1:0] mem_r [0:(2**ADDR_W)-1];
   logic [DMEM_WORD_W-1:0] rdata_r;

   // Byte-masked write and registered read
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      if (re) begin
         rdata_r <= mem_r[addr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder
// Wait-stated data-memory responder. Captures one load/store in IDLE,
// waits WAIT_CYCLES cycles, then commits the store or returns load data
// with a one-cycle ready pulse. Addresses outside the 2^ADDR_W-word window
// complete with err=1 and no write.
// Build option: DMEM_MISALIGN_CHECK_EN - when defined, addr[1:0] != 0 is
// also an error; otherwise the low address bits are ignored.
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset
//   req    in   request valid, sampled only in IDLE
//   we     in   1 = store, 0 = load
//   addr   in   byte address
//   wdata  in   store data
//   be     in   byte enables for stores
//   rdata  out  load data, non-zero only while ready=1
//   ready  out  one-cycle completion pulse
//   err    out  completion with error, valid while ready=1
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err
);

   localparam logic [DMEM_CNT_W-1:0] CNT_INIT = DMEM_CNT_W'(WAIT_CYCLES);
   localparam logic [DMEM_CNT_W-1:0] CNT_ONE  = DMEM_CNT_W'(1);
   localparam bit                    NO_WAIT  = (WAIT_CYCLES == 0);
`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MISALIGN_EN = 1'b1;
`else
   localparam bit MISALIGN_EN = 1'b0;
`endif

   // Configuration sanity: the counter cannot hold more, and the range
   // check needs at least one upper address bit.
   if (WAIT_CYCLES < 0 || WAIT_CYCLES > (2**DMEM_CNT_W) - 1) begin : g_bad_wait
      $error("dmem_responder: WAIT_CYCLES=%0d outside 0..15", WAIT_CYCLES);
   end
   if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
      $error("dmem_responder: ADDR_W=%0d outside 1..29", ADDR_W);
   end

   dmem_state_t             state_r;
   logic [DMEM_CNT_W-1:0]   cnt_r;
   logic                    we_r;
   logic [31:0]             addr_r;
   logic [31:0]             wdata_r;
   logic [3:0]              be_r;
   logic                    ready_r;
   logic                    err_r;
   logic                    rvalid_r;

   logic                    cur_we_s;
   logic [31:0]             cur_addr_s;
   logic [31:0]             cur_wdata_s;
   logic [3:0]              cur_be_s;
   logic                    range_err_s;
   logic                    mis_err_s;
   logic                    err_s;
   logic                    go_resp_s;
   logic                    mem_we_s;
   logic                    mem_re_s;
   logic [31:0]             arr_rdata_s;

   // Request fields as seen on the edge entering RESP. With zero wait
   // cycles that edge is also the capture edge, so the live inputs are used.
   always_comb begin
      cur_we_s    = we_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
      cur_be_s    = be_r;
      if (state_r == IDLE) begin
         cur_we_s    = we;
         cur_addr_s  = addr;
         cur_wdata_s = wdata;
         cur_be_s    = be;
      end else begin
         cur_we_s    = we_r;
         cur_addr_s  = addr_r;
         cur_wdata_s = wdata_r;
         cur_be_s    = be_r;
      end

      range_err_s = |cur_addr_s[31:ADDR_W+2];
      mis_err_s   = MISALIGN_EN & (|cur_addr_s[1:0]);
      err_s       = range_err_s | mis_err_s;

      go_resp_s = 1'b0;
      case (state_r)
         IDLE:    go_resp_s = req & NO_WAIT;
         WAIT:    go_resp_s = (cnt_r == CNT_ONE);
         default: go_resp_s = 1'b0;
      endcase

      // rst gating keeps a store from committing on an edge seen during reset
      mem_we_s = go_resp_s & cur_we_s  & ~err_s & ~rst;
      mem_re_s = go_resp_s & ~cur_we_s & ~err_s & ~rst;
   end

   // FSM, wait counter, request latch and registered completion flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         cnt_r    <= '0;
         we_r     <= 1'b0;
         addr_r   <= 32'h0000_0000;
         wdata_r  <= 32'h0000_0000;
         be_r     <= 4'h0;
         ready_r  <= 1'b0;
         err_r    <= 1'b0;
         rvalid_r <= 1'b0;
      end else begin
         ready_r  <= go_resp_s;
         err_r    <= go_resp_s & err_s;
         rvalid_r <= mem_re_s;
         case (state_r)
            IDLE: begin
               if (req) begin
                  we_r    <= we;
                  addr_r  <= addr;
                  wdata_r <= wdata;
                  be_r    <= be;
                  cnt_r   <= CNT_INIT;
                  state_r <= NO_WAIT ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt_r <= cnt_r - CNT_ONE;
               if (go_resp_s) begin
                  state_r <= RESP;
               end
            end
            RESP:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   dmem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (mem_we_s),
      .re    (mem_re_s),
      .addr  (cur_addr_s[ADDR_W+1:2]),
      .wdata (cur_wdata_s),
      .be    (cur_be_s),
      .rdata (arr_rdata_s)
   );

   // The array read register has no reset, so a registered flag qualifies it
   assign rdata = rvalid_r ? arr_rdata_s : 32'h0000_0000;
   assign ready = ready_r;
   assign err   = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder
// Directed bench for dmem_responder (ADDR_W=8, WAIT_CYCLES=2): a table of
// single transactions with hand-computed results, plus hand-written
// sequences for held req, req toggled during WAIT, and reset mid-store.
module tb_dmem_responder;

   localparam int ADDR_W      = 8;
   localparam int WAIT_CYCLES = 2;
   localparam int NV          = 21;
`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic [31:0] rdata;
   logic        ready;
   logic        err;

   int n_vec  = 0;
   int n_miss = 0;

   vec_t vecs [0:NV-1];

   always #5 clk = ~clk;

   dmem_responder #(
      .ADDR_W      (ADDR_W),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .be    (be),
      .rdata (rdata),
      .ready (ready),
      .err   (err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // One transaction: drive req for the capture edge, then wait (bounded)
   // for ready. lat counts falling edges after capture (3 for WAIT_CYCLES=2).
   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] b, output int lat, output logic [31:0] rd,
                      output logic e, output logic extra);
      lat = 99;
      rd  = 32'hFFFF_FFFF;
      e   = 1'b1;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; wdata = d; be = b;
      @(negedge clk);
      req = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (k > 1) @(negedge clk);
         if (ready) begin
            lat = k;
            rd  = rdata;
            e   = err;
            break;
         end
      end
      @(negedge clk);
      extra = ready;
   endtask

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        e;
      logic        extra;
      logic [31:0] mask;
      int          bad_idle;

      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_AA00, 4'h2, 32'h0000_0000, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_AAEF, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0400, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
      vecs[5]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
      vecs[6]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'h0, 32'h1122_3344, 1'b0};
      vecs[8]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
      vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_AAEF, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h9, 32'h0000_0000, 1'b0};
      vecs[11] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'h11AD_AA44, 1'b0};
      vecs[12] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 32'h0000_0000, 1'b0};
      vecs[13] = '{1'b0, 32'h0000_03FC, 32'h0000_0000, 4'h0, 32'hCAFE_F00D, 1'b0};
      vecs[14] = '{1'b0, 32'h8000_0000, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1};
      vecs[15] = '{1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
      vecs[16] = '{1'b1, 32'h0000_0012, 32'h5A5A_5A5A, 4'hF, 32'h0000_0000, MIS};
      vecs[17] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0,
                   (MIS ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A), 1'b0};
      vecs[18] = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'h0,
                   (MIS ? 32'h0000_0000 : 32'h5A5A_5A5A), MIS};
      vecs[19] = '{1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 32'h0000_0000, 1'b0};
      vecs[20] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h0BAD_F00D, 1'b0};

      rst = 1'b1; req = 1'b0; we = 1'b0;
      addr = 32'h0; wdata = 32'h0; be = 4'h0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("reset ready", {31'b0, ready}, 32'h0);
      check("reset err",   {31'b0, err},   32'h0);
      check("reset rdata", rdata,          32'h0);
      rst = 1'b0;

      // Table-driven single transactions
      for (int i = 0; i < NV; i++) begin
         txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, rd, e, extra);
         check($sformatf("v%0d latency", i), lat, 32'd3);
         check($sformatf("v%0d rdata", i),   rd,  vecs[i].exp_rdata);
         check($sformatf("v%0d err", i),     {31'b0, e}, {31'b0, vecs[i].exp_err});
         check($sformatf("v%0d one-cycle ready", i), {31'b0, extra}, 32'h0);
      end

      // req held high for 8 cycles: two captures, pulses in cycles 3 and 7
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h0000_0000; be = 4'h0;
      mask = 32'h0;
      bad_idle = 0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (ready) mask[i] = 1'b1;
         if (!ready && (rdata != 32'h0 || err)) bad_idle++;
         if (i == 7) req = 1'b0;
      end
      check("held_req pulse cycles", mask, 32'h0000_0088);
      check("held_req quiet outputs", bad_idle, 32'd0);

      // req dropped then raised again during WAIT: only one completion
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h0000_0020; be = 4'h0;
      mask = 32'h0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (ready) mask[i] = 1'b1;
         if (i == 3) check("toggle rdata", rdata, 32'h0BAD_F00D);
         if (i == 1) req = 1'b0;
         if (i == 2) req = 1'b1;
         if (i == 3) req = 1'b0;
      end
      check("toggle pulse cycles", mask, 32'h0000_0008);

      // Reset during WAIT of a store: nothing committed, no ready pulse
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h0000_0020; wdata = 32'h1234_5678; be = 4'hF;
      @(negedge clk);
      req = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst ready", {31'b0, ready}, 32'h0);
      check("midrst err",   {31'b0, err},   32'h0);
      check("midrst rdata", rdata,          32'h0);
      @(negedge clk);
      rst = 1'b0;
      mask = 32'h0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (ready || err || rdata != 32'h0) mask[i] = 1'b1;
      end
      check("midrst no activity", mask, 32'h0);
      txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, lat, rd, e, extra);
      check("midrst reload latency", lat, 32'd3);
      check("midrst reload rdata",   rd,  32'h0BAD_F00D);
      check("midrst reload err",     {31'b0, e}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
